// File: rtl/opb_register_bank_ppc2simulink_pkg.sv
// Shared definitions for the OPB register bank: bus width, FSM states and helpers.
package opb_register_bank_ppc2simulink_pkg;

  localparam int OPB_DW = 32;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } opb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // be[3] is OPB_BE[0], which owns user bits [31:24]
  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/opb_reg_pulse_timer.sv
// Down-counter for one pulse-mode register: load restarts the count, expire flags the 1->0 step.
// A load on the same edge suppresses expiry so a fresh write always survives.
module opb_reg_pulse_timer #(
  parameter logic [15:0] PULSE_LEN = 16'd1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  logic [15:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= PULSE_LEN;
    end else if (count_q != 16'd0) begin
      count_q <= count_q - 16'd1;
    end
  end

  assign expire = ~load & (count_q == 16'd1);

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing NUM_REGS byte-writable 32-bit control registers with write strobes.
// Single-cycle ack after each hit; optional per-register self-clearing pulse mode.
module opb_register_bank_ppc2simulink
  import opb_register_bank_ppc2simulink_pkg::*;
#(
  parameter logic [31:0]          C_BASEADDR   = 32'h01188000,
  parameter logic [31:0]          C_HIGHADDR   = 32'h011880FF,
  parameter int                   C_OPB_AWIDTH = 32,
  parameter int                   C_OPB_DWIDTH = 32,
  parameter string                C_FAMILY     = "virtex6",
  parameter int                   NUM_REGS     = 8,
  parameter logic [31:0]          RESET_VAL    = 32'h0,
  parameter logic [NUM_REGS-1:0]  PULSE_REGS   = '0,
  parameter logic [15:0]          PULSE_LEN    = 16'd1
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
  input  logic [0:3]                 OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
  output logic                       Sl_xferAck,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic [NUM_REGS*32-1:0]     user_data_out,
  output logic [NUM_REGS-1:0]        user_wr_stb
);

  localparam int IW = clog2(NUM_REGS);

  opb_state_t              state_q, state_d;
  logic [31:0]             addr, wdat, offset;
  logic [29:0]             word_idx;
  logic [IW-1:0]           sel;
  logic [3:0]              be;
  logic                    in_win, idx_ok, req, hit;
  logic [NUM_REGS-1:0]     wr_vec, expire, stb_q;
  logic [31:0]             rdat_q;
  logic [NUM_REGS-1:0][31:0] regs;
  logic                    unused_bits;

  assign addr     = OPB_ABus;
  assign wdat     = OPB_DBus;
  assign be       = OPB_BE;
  assign offset   = addr - C_BASEADDR;
  assign word_idx = offset[31:2];
  assign sel      = word_idx[IW-1:0];
  assign in_win   = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign idx_ok   = word_idx < 30'(NUM_REGS);
  assign req      = OPB_select & in_win;
  assign hit      = req & (state_q == ST_IDLE);

  assign unused_bits = ^{OPB_seqAddr, offset[1:0]};

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // ACK always falls back to IDLE, so a held select re-hits only every other cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_vec = '0;
    if (hit & ~OPB_RNW & idx_ok) wr_vec[sel] = 1'b1;
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      rdat_q <= '0;
      stb_q  <= '0;
    end else begin
      rdat_q <= (hit & OPB_RNW & idx_ok) ? regs[sel] : 32'h0;
      stb_q  <= wr_vec;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (PULSE_REGS[r]) begin : g_pulse
      opb_reg_pulse_timer #(.PULSE_LEN(PULSE_LEN)) u_timer (
        .clk    (OPB_Clk),
        .rst    (OPB_Rst),
        .load   (wr_vec[r]),
        .expire (expire[r])
      );
    end else begin : g_hold
      assign expire[r] = 1'b0;
    end
    assign user_data_out[32*r +: 32] = regs[r];
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= RESET_VAL;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_vec[r])      regs[r] <= be_merge(regs[r], wdat, be);
        else if (expire[r]) regs[r] <= '0;
      end
    end
  end

  assign Sl_xferAck  = (state_q == ST_ACK);
  assign Sl_DBus     = rdat_q;
  assign user_wr_stb = stb_q;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for the OPB register bank: decode, byte lanes, ack timing, pulse mode, reset.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01188000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [0:31]   abus = '0;
  logic [0:3]    be = '0;
  logic [0:31]   dbus = '0;
  logic          rnw = 1'b0;
  logic          sel = 1'b0;
  logic          seq = 1'b0;
  logic [0:31]   sl_dbus;
  logic          sl_ack, sl_err, sl_retry, sl_tout;
  logic [255:0]  udata;
  logic [7:0]    ustb;

  logic [255:0]  model = '0;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(
    .NUM_REGS   (8),
    .RESET_VAL  (32'h0),
    .PULSE_REGS (8'h01),
    .PULSE_LEN  (16'd3)
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .OPB_ABus      (abus),
    .OPB_BE        (be),
    .OPB_DBus      (dbus),
    .OPB_RNW       (rnw),
    .OPB_select    (sel),
    .OPB_seqAddr   (seq),
    .Sl_DBus       (sl_dbus),
    .Sl_xferAck    (sl_ack),
    .Sl_errAck     (sl_err),
    .Sl_retry      (sl_retry),
    .Sl_toutSup    (sl_tout),
    .user_data_out (udata),
    .user_wr_stb   (ustb)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transfer: drive on a falling edge, sample the ack cycle, then the idle cycle after it.
  task automatic xfer(input string tag, input logic r, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic exp_ack, input logic [31:0] exp_rd,
                      input logic [7:0] exp_stb);
    @(negedge clk);
    abus = a; be = b; dbus = d; rnw = r; sel = 1'b1;
    @(negedge clk);
    check({tag, " ack"}, 256'(sl_ack), 256'(exp_ack));
    check({tag, " rdata"}, 256'(sl_dbus), 256'(exp_rd));
    check({tag, " stb"}, 256'(ustb), 256'(exp_stb));
    sel = 1'b0;
    @(negedge clk);
    check({tag, " ack_drop"}, 256'(sl_ack), 256'd0);
    check({tag, " dbus_idle"}, 256'(sl_dbus), 256'd0);
    check({tag, " stb_drop"}, 256'(ustb), 256'd0);
    check({tag, " regs"}, udata, model);
  endtask

  logic [31:0] hold_dat [4];
  logic        hold_ack [4];
  logic [31:0] pulse_dat [7];
  logic        pulse_stb [7];

  initial begin
    hold_ack  = '{1'b1, 1'b0, 1'b1, 1'b0};
    hold_dat  = '{32'hDEAABEEF, 32'h0, 32'hDEAABEEF, 32'h0};
    pulse_dat = '{32'h5, 32'h5, 32'h5, 32'h5, 32'h5, 32'h0, 32'h0};
    pulse_stb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    #12;
    check("reset ack", 256'(sl_ack), 256'd0);
    check("reset dbus", 256'(sl_dbus), 256'd0);
    check("reset stb", 256'(ustb), 256'd0);
    check("reset regs", udata, 256'd0);
    check("tieoffs", 256'({sl_err, sl_retry, sl_tout}), 256'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      xfer("rd_reset", 1'b1, BASE + 32'(4 * i), 4'hF, 32'h0, 1'b1, 32'h0, 8'h00);

    model[127:96] = 32'hDEADBEEF;
    xfer("wr_full", 1'b0, BASE + 32'h0C, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0, 8'h08);
    model[127:96] = 32'hDEAABEEF;
    xfer("wr_lane1", 1'b0, BASE + 32'h0C, 4'b0100, 32'h00AA0000, 1'b1, 32'h0, 8'h08);
    xfer("rd_idx3", 1'b1, BASE + 32'h0C, 4'hF, 32'h0, 1'b1, 32'hDEAABEEF, 8'h00);

    @(negedge clk);
    abus = BASE + 32'h0C; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("hold ack c%0d", k), 256'(sl_ack), 256'(hold_ack[k]));
      check($sformatf("hold dbus c%0d", k), 256'(sl_dbus), 256'(hold_dat[k]));
    end
    sel = 1'b0;
    @(negedge clk);
    check("hold ack end", 256'(sl_ack), 256'd0);

    xfer("wr_oob", 1'b0, BASE + 32'h40, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0, 8'h00);
    xfer("rd_oob", 1'b1, BASE + 32'h40, 4'hF, 32'h0, 1'b1, 32'h0, 8'h00);
    xfer("wr_outside", 1'b0, BASE + 32'h100, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0, 8'h00);
    xfer("rd_outside", 1'b1, BASE + 32'h100, 4'hF, 32'h0, 1'b0, 32'h0, 8'h00);

    // Pulse register 0: first write, rewrite one cycle after the ack, then expiry
    @(negedge clk);
    abus = BASE; rnw = 1'b0; be = 4'hF; dbus = 32'h5; sel = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("pulse data c%0d", k), 256'(udata[31:0]), 256'(pulse_dat[k]));
      check($sformatf("pulse stb c%0d", k), 256'(ustb[0]), 256'(pulse_stb[k]));
      if (k == 0 || k == 2) sel = 1'b0;
      if (k == 1) sel = 1'b1;
    end
    xfer("rd_pulse_expired", 1'b1, BASE, 4'hF, 32'h0, 1'b1, 32'h0, 8'h00);

    @(negedge clk);
    abus = BASE + 32'h14; rnw = 1'b0; be = 4'hF; dbus = 32'h12345678; sel = 1'b1;
    #2 rst = 1'b1;
    #1;
    model = '0;
    check("rst_mid ack", 256'(sl_ack), 256'd0);
    check("rst_mid regs async", udata, model);
    @(negedge clk);
    check("rst_mid ack held", 256'(sl_ack), 256'd0);
    check("rst_mid stb", 256'(ustb), 256'd0);
    check("rst_mid dbus", 256'(sl_dbus), 256'd0);
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    xfer("rd_idx5_after_rst", 1'b1, BASE + 32'h14, 4'hF, 32'h0, 1'b1, 32'h0, 8'h00);
    xfer("rd_idx3_after_rst", 1'b1, BASE + 32'h0C, 4'hF, 32'h0, 1'b1, 32'h0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
